// File: rtl/coprocessor_stream.sv
// Frame coprocessor: accepts one N_BYTES frame, transforms it one byte per cycle
// (pass / reverse / xor-key / checksum) and holds the result until the TX side takes it.
//
// state | meaning
// IDLE  | waiting for a frame, din_ready=1
// PROC  | one byte per cycle, idx 0..N_BYTES-1
// DONE  | result held on dout with dout_valid=1 until dout_ready
module coprocessor_stream #(
  parameter int          N_BYTES = 18,
  parameter logic [7:0]  XOR_KEY = 8'h5A,
  parameter int          CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*N_BYTES-1:0]   din,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [1:0]             mode,
  output logic [8*N_BYTES-1:0]   dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   busy,
  output logic [CNT_W-1:0]       frame_cnt
);

  localparam int IDX_W = $clog2(N_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BYTES - 1);

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_REV  = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_SUM  = 2'd3;

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, rev_idx;
  logic [1:0]       mode_r;
  logic [7:0]       in_buf  [N_BYTES];
  logic [7:0]       res_buf [N_BYTES];
  logic [7:0]       sum, xacc;
  logic [7:0]       cur_byte, res_byte, sum_nxt, xacc_nxt;
  logic             accept, last, xfer;

  assign din_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign dout_valid = (state == DONE);
  assign accept     = din_ready && din_valid;
  assign last       = (state == PROC) && (idx == IDX_LAST);
  assign xfer       = dout_valid && dout_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (din_valid)  state_nxt = PROC;
      PROC:    if (last)       state_nxt = DONE;
      DONE:    if (dout_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rev_idx  = IDX_LAST - idx;
    cur_byte = in_buf[idx];
    sum_nxt  = sum + cur_byte;
    xacc_nxt = xacc ^ cur_byte;
    res_byte = 8'h00;
    case (mode_r)
      MODE_PASS: res_byte = cur_byte;
      MODE_REV:  res_byte = in_buf[rev_idx];
      MODE_XOR:  res_byte = cur_byte ^ XOR_KEY;
      default:   res_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      mode_r    <= MODE_PASS;
      sum       <= 8'h00;
      xacc      <= 8'h00;
      dout      <= '0;
      frame_cnt <= '0;
      for (int i = 0; i < N_BYTES; i++) begin
        in_buf[i]  <= 8'h00;
        res_buf[i] <= 8'h00;
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < N_BYTES; i++) in_buf[i] <= din[8*i +: 8];
        mode_r <= mode;
        idx    <= '0;
        sum    <= 8'h00;
        xacc   <= 8'h00;
      end
      if (state == PROC) begin
        res_buf[idx] <= res_byte;
        sum          <= sum_nxt;
        xacc         <= xacc_nxt;
        if (last) begin
          // the final byte is still combinational, so take it directly
          for (int i = 0; i < N_BYTES; i++) begin
            if (mode_r == MODE_SUM)
              dout[8*i +: 8] <= (i == 0) ? sum_nxt : (i == 1) ? xacc_nxt : 8'h00;
            else
              dout[8*i +: 8] <= (i == N_BYTES - 1) ? res_byte : res_buf[i];
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (xfer) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_coprocessor_stream.sv
// Scoreboard bench for coprocessor_stream: driver pushes expected frames, a
// negedge monitor pops and compares whenever a new result appears on dout.
module tb_coprocessor_stream;
  localparam int N  = 18;
  localparam int W  = 8 * N;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [1:0]    mode = 2'd0;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  coprocessor_stream #(.N_BYTES(N), .XOR_KEY(8'h5A), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .mode(mode), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           acc_cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            acc_log[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [CW-1:0] exp_cnt = '0;
  bit            holding = 0;
  bit            prev_xfer = 0;
  bit            rand_rdy = 0;
  logic [W-1:0]  held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] f, input logic [1:0] m);
    logic [7:0]   b [N];
    int           s = 0;
    int           x = 0;
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) b[i] = f[8*i +: 8];
    case (m)
      2'd0: r = f;
      2'd1: for (int i = 0; i < N; i++) r[8*i +: 8] = b[N-1-i];
      2'd2: for (int i = 0; i < N; i++) r[8*i +: 8] = b[i] ^ 8'h5A;
      default: begin
        for (int i = 0; i < N; i++) begin
          s = s + int'(b[i]);
          x = x ^ int'(b[i]);
        end
        r[7:0]  = 8'(s % 256);
        r[15:8] = 8'(x);
      end
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] rand_frame();
    logic [W-1:0] f;
    for (int i = 0; i < N; i++) f[8*i +: 8] = 8'($urandom_range(0, 255));
    return f;
  endfunction

  // monitor: a new result is one that appears while nothing is being held
  always @(negedge clk) begin
    if (!rst) begin
      holding   = 0;
      prev_xfer = 0;
    end else begin
      if (prev_xfer) check_int("valid_one_cycle", int'(dout_valid), 0);
      prev_xfer = 0;
      if (dout_valid) begin
        if (!holding) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", dout);
          end else begin
            mon_e = sb.pop_front();
            check_vec("dout", dout, mon_e.data);
            check_int("latency", cyc - mon_e.acc_cyc, N);
          end
          held    = dout;
          holding = 1;
        end else begin
          check_vec("dout_stable", dout, held);
        end
        if (dout_ready) begin
          holding   = 0;
          prev_xfer = 1;
          exp_cnt   = exp_cnt + 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) dout_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic send(input logic [W-1:0] frame, input logic [1:0] m,
                      input logic [W-1:0] expv, input bit keep);
    bit   done = 0;
    exp_t tmp;
    @(posedge clk); #1;
    din       = frame;
    mode      = m;
    din_valid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (din_ready && rst) begin
        done        = 1;
        tmp.data    = expv;
        tmp.acc_cyc = cyc + 1;
        sb.push_back(tmp);
        acc_log.push_back(cyc + 1);
      end
      @(posedge clk); #1;
    end
    if (!keep) din_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (!busy && !dout_valid && !holding && sb.size() == 0) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] seq, rev_seq, all_ff, all_a5, f;
    logic [1:0]   m;
    bit           seen;
    int           base;

    for (int i = 0; i < N; i++) begin
      seq[8*i +: 8]     = 8'(i + 1);
      rev_seq[8*i +: 8] = 8'(N - i);
      all_ff[8*i +: 8]  = 8'hFF;
      all_a5[8*i +: 8]  = 8'hA5;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_dout_valid", int'(dout_valid), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_frame_cnt", int'(frame_cnt), 0);
    check_vec("rst_dout", dout, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_int("din_ready_after_rst", int'(din_ready), 1);

    // abort mid-PROC at idx=7
    dout_ready = 1'b1;
    send(seq, 2'd0, seq, 0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    sb.delete();
    check_int("abort_dout_valid", int'(dout_valid), 0);
    check_int("abort_busy", int'(busy), 0);
    check_vec("abort_dout", dout, '0);
    check_int("abort_frame_cnt", int'(frame_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (N + 6) @(negedge clk);
    check_int("abort_no_output_cnt", int'(frame_cnt), 0);

    // PASS with ready already high
    send(seq, 2'd0, seq, 0);
    wait_idle();
    check_int("pass_frame_cnt", int'(frame_cnt), 1);

    // REVERSE with a 5-cycle TX stall and ignored din_valid pulses
    dout_ready = 1'b0;
    send(seq, 2'd1, rev_seq, 0);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (dout_valid) seen = 1;
    end
    check_int("rev_valid_seen", int'(seen), 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      din       = rand_frame();
      din_valid = 1'b1;
      @(negedge clk);
      check_int("stall_din_ready", int'(din_ready), 0);
      check_int("stall_dout_valid", int'(dout_valid), 1);
    end
    @(posedge clk); #1;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    wait_idle();
    check_int("rev_frame_cnt", int'(frame_cnt), int'(exp_cnt));

    // XOR and CHECKSUM with known answers
    send(all_ff, 2'd2, all_a5, 0);
    wait_idle();
    send(seq, 2'd3, W'(16'h13AB), 0);
    wait_idle();

    // back-to-back with din_valid held high
    base = acc_log.size();
    for (int k = 0; k < 3; k++) begin
      f = rand_frame();
      m = 2'($urandom_range(0, 3));
      send(f, m, model(f, m), 1);
    end
    din_valid = 1'b0;
    wait_idle();
    check_int("spacing_0_1", acc_log[base+1] - acc_log[base], N + 2);
    check_int("spacing_1_2", acc_log[base+2] - acc_log[base+1], N + 2);

    // randomized frames and modes with random TX backpressure
    rand_rdy = 1;
    for (int k = 0; k < 25; k++) begin
      f = rand_frame();
      m = 2'($urandom_range(0, 3));
      send(f, m, model(f, m), 0);
    end
    rand_rdy = 0;
    @(posedge clk); #1;
    dout_ready = 1'b1;
    wait_idle();
    check_int("random_frame_cnt", int'(frame_cnt), int'(exp_cnt));

    // frame_cnt wraps from all-ones
    @(posedge clk); #1;
    force dut.frame_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt;
    exp_cnt = 16'hFFFF;
    f = rand_frame();
    send(f, 2'd0, f, 0);
    wait_idle();
    check_int("frame_cnt_wrap", int'(frame_cnt), 0);
    check_int("frame_cnt_model", int'(frame_cnt), int'(exp_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
